// File: rtl/mag_metric_pkg.sv
// Shared width derivations, FSM encoding and helpers for the magnitude-difference
// squared metric and its iterative square-root units.
package mag_metric_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SQRT = 2'd1,
      POST = 2'd2
   } state_t;

   function automatic int clog2_f(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

   function automatic int sum_w_f(input int in_w);
      return 2 * in_w;
   endfunction

   function automatic int root_w_f(input int in_w);
      return in_w;
   endfunction

   function automatic int acc_w_f(input int in_w, input int acc_len);
      return 2 * in_w + clog2_f(acc_len);
   endfunction

endpackage

// File: rtl/sqrt_iter.sv
// Non-restoring integer square root, one root bit per clock. The radicand is
// captured on start; root holds floor(sqrt(radicand)) once the last bit is in.
module sqrt_iter
   import mag_metric_pkg::*;
#(
   parameter int  SUM_W  = 18,
   localparam int ROOT_W = SUM_W / 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [SUM_W-1:0]  radicand,
   output logic [ROOT_W-1:0] root,
   output logic              done
);

   localparam int REM_W = ROOT_W + 3;
   localparam int CNT_W = clog2_f(ROOT_W + 1);

   logic [SUM_W-1:0]  rad_q;
   logic [REM_W-1:0]  rem_q;
   logic [REM_W-1:0]  rem_sh;
   logic [REM_W-1:0]  rem_nxt;
   logic [ROOT_W-1:0] root_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              busy_q;

   // The remainder is kept in two's complement; its sign picks subtract or add
   // for the next step and becomes the inverted next root bit.
   always_comb begin
      rem_sh = {rem_q[REM_W-3:0], rad_q[SUM_W-1 -: 2]};
      if (rem_q[REM_W-1]) rem_nxt = rem_sh + REM_W'({root_q, 2'b11});
      else                rem_nxt = rem_sh - REM_W'({root_q, 2'b01});
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rad_q  <= '0;
         rem_q  <= '0;
         root_q <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (start) begin
         rad_q  <= radicand;
         rem_q  <= '0;
         root_q <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b1;
      end else if (busy_q) begin
         rad_q  <= rad_q << 2;
         rem_q  <= rem_nxt;
         root_q <= {root_q[ROOT_W-2:0], ~rem_nxt[REM_W-1]};
         cnt_q  <= cnt_q + 1'b1;
         if (cnt_q == CNT_W'(ROOT_W - 1)) busy_q <= 1'b0;
      end
   end

   // High during the final iteration, so root is complete on the following cycle.
   assign done = busy_q && (cnt_q == CNT_W'(ROOT_W - 1));
   assign root = root_q;

endmodule

// File: rtl/mag_diff_sq_acc.sv
// Squared difference of two sample magnitudes, emitted per sample or summed over
// an ACC_LEN-sample window as a sample-timing-offset metric.
module mag_diff_sq_acc
   import mag_metric_pkg::*;
#(
   parameter int  IN_W    = 9,
   parameter int  ACC_LEN = 16,
   localparam int SUM_W   = sum_w_f(IN_W),
   localparam int ROOT_W  = root_w_f(IN_W),
   localparam int ACC_W   = acc_w_f(IN_W, ACC_LEN)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic signed [IN_W-1:0] r1,
   input  logic signed [IN_W-1:0] i1,
   input  logic signed [IN_W-1:0] r2,
   input  logic signed [IN_W-1:0] i2,
   input  logic                   mode,
   input  logic                   acc_clr,
   output logic [ACC_W-1:0]       out_data,
   output logic                   out_valid
);

   localparam int CNT_W = clog2_f(ACC_LEN);

   state_t              state_q, state_nxt;
   logic                accept;
   logic [SUM_W-1:0]    r1_sq, i1_sq, r2_sq, i2_sq;
   logic [SUM_W-1:0]    s1, s2;
   logic [ROOT_W-1:0]   root1, root2;
   logic                done1, done2;
   logic signed [ROOT_W:0] d;
   logic [2*IN_W-1:0]   m;
   logic [ACC_W-1:0]    acc_q, acc_sum;
   logic [CNT_W-1:0]    cnt_q;
   logic                mode_q, drop_q, win_last;

   assign r1_sq = SUM_W'(r1) * SUM_W'(r1);
   assign i1_sq = SUM_W'(i1) * SUM_W'(i1);
   assign r2_sq = SUM_W'(r2) * SUM_W'(r2);
   assign i2_sq = SUM_W'(i2) * SUM_W'(i2);
   assign s1    = r1_sq + i1_sq;
   assign s2    = r2_sq + i2_sq;

   sqrt_iter #(.SUM_W(SUM_W)) u_sqrt1 (
      .clk(clk), .rst_n(rst_n), .start(accept), .radicand(s1), .root(root1), .done(done1)
   );
   sqrt_iter #(.SUM_W(SUM_W)) u_sqrt2 (
      .clk(clk), .rst_n(rst_n), .start(accept), .radicand(s2), .root(root2), .done(done2)
   );

   assign d        = {1'b0, root1} - {1'b0, root2};
   assign m        = (2*IN_W)'(d) * (2*IN_W)'(d);
   assign acc_sum  = acc_q + ACC_W'(m);
   assign win_last = (cnt_q == CNT_W'(ACC_LEN - 1));

   // Both roots start together and take the same number of steps, so done1 alone paces the FSM.
   always_comb begin
      state_nxt = state_q;
      in_ready  = 1'b0;
      accept    = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            accept   = in_valid;
            if (in_valid) state_nxt = SQRT;
         end
         SQRT:    if (done1) state_nxt = POST;
         POST:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         out_valid <= 1'b0;
         out_data  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         mode_q    <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         out_valid <= 1'b0;
         // A clear while a sample is in flight keeps that sample out of the new window.
         if (accept) begin
            drop_q <= 1'b0;
            if (cnt_q == '0 || acc_clr) mode_q <= mode;
         end else if (acc_clr && state_q != IDLE) begin
            drop_q <= 1'b1;
         end
         if (state_q == POST && !mode_q) begin
            out_data  <= ACC_W'(m);
            out_valid <= 1'b1;
         end
         if (acc_clr) begin
            acc_q <= '0;
            cnt_q <= '0;
         end else if (state_q == POST && mode_q && !drop_q) begin
            if (win_last) begin
               out_data  <= acc_sum;
               out_valid <= 1'b1;
               acc_q     <= '0;
               cnt_q     <= '0;
            end else begin
               acc_q <= acc_sum;
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end

   logic unused_done2;
   assign unused_done2 = done2;

endmodule
